// File: rtl/diff_map_pkg.sv
// Shared types and parameter defaults for the diff_map engine.
package diff_map_pkg;

    localparam int unsigned WORD_W_DEF = 32;
    localparam int unsigned ADDR_W_DEF = 6;

    // Element operation: A-B, A+B, A^B, signed saturating A-B
    typedef enum logic [1:0] {
        OP_SUB  = 2'b00,
        OP_ADD  = 2'b01,
        OP_XOR  = 2'b10,
        OP_SSUB = 2'b11
    } op_e;

    typedef enum logic [1:0] {
        S_IDLE  = 2'b00,
        S_RUN   = 2'b01,
        S_DRAIN = 2'b10,
        S_FIN   = 2'b11
    } state_e;

endpackage

// File: rtl/diff_map_if.sv
// Request, status and register-file port bundle for diff_map_engine.
interface diff_map_if #(
    parameter int unsigned WORD_W = diff_map_pkg::WORD_W_DEF,
    parameter int unsigned ADDR_W = diff_map_pkg::ADDR_W_DEF
);
    import diff_map_pkg::*;

    logic              start;
    logic [ADDR_W-1:0] origin;
    logic [ADDR_W-1:0] modifier;
    logic [ADDR_W:0]   length;
    op_e               op;
    logic              cond_en;
    logic              cond_flag;
    logic              busy;
    logic              done;
    logic              skipped;
    logic [ADDR_W-1:0] rd_addr_a;
    logic [ADDR_W-1:0] rd_addr_b;
    logic [WORD_W-1:0] rd_data_a;
    logic [WORD_W-1:0] rd_data_b;
    logic              wr_en;
    logic [ADDR_W-1:0] wr_addr;
    logic [WORD_W-1:0] wr_data;

    modport master (
        output start, origin, modifier, length, op, cond_en, cond_flag,
               rd_data_a, rd_data_b,
        input  busy, done, skipped, rd_addr_a, rd_addr_b, wr_en, wr_addr, wr_data
    );

    modport slave (
        input  start, origin, modifier, length, op, cond_en, cond_flag,
               rd_data_a, rd_data_b,
        output busy, done, skipped, rd_addr_a, rd_addr_b, wr_en, wr_addr, wr_data
    );

endinterface

// File: rtl/diff_map_alu.sv
// Combinational element datapath for diff_map_engine.
// DIFF_MAP_SAT_EN: when defined, OP_SSUB clamps the signed difference;
// otherwise OP_SSUB is a plain modular subtract.
module diff_map_alu #(
    parameter int unsigned WORD_W = diff_map_pkg::WORD_W_DEF
) (
    input  diff_map_pkg::op_e  op,
    input  logic [WORD_W-1:0]  a,
    input  logic [WORD_W-1:0]  b,
    output logic [WORD_W-1:0]  result
);
    import diff_map_pkg::*;

    logic [WORD_W-1:0] diff_c;

    // Select the element result for the latched operation
    always_comb begin
        diff_c = a - b;
        result = diff_c;
        case (op)
            OP_SUB:  result = diff_c;
            OP_ADD:  result = a + b;
            OP_XOR:  result = a ^ b;
            OP_SSUB: begin
`ifdef DIFF_MAP_SAT_EN
                // Overflow only when operand signs differ and the result sign flips away from A
                if ((a[WORD_W-1] != b[WORD_W-1]) && (diff_c[WORD_W-1] != a[WORD_W-1])) begin
                    result = a[WORD_W-1] ? {1'b1, {(WORD_W-1){1'b0}}}
                                         : {1'b0, {(WORD_W-1){1'b1}}};
                end else begin
                    result = diff_c;
                end
`else
                result = diff_c;
`endif
            end
            default: result = diff_c;
        endcase
    end

endmodule

// File: rtl/diff_map_engine.sv
// Range engine: dst[origin+i] = op(A[origin+i], B[modifier+i]) for i < length,
// with snapshot semantics via overlap-aware processing direction.
// Optional DIFF_MAP_SAT_EN enables saturation of OP_SSUB inside diff_map_alu.
module diff_map_engine #(
    parameter int unsigned WORD_W = diff_map_pkg::WORD_W_DEF,
    parameter int unsigned ADDR_W = diff_map_pkg::ADDR_W_DEF
) (
    input  logic      clk,
    input  logic      rst,
    diff_map_if.slave bus
);
    import diff_map_pkg::*;

    localparam int unsigned LEN_W = ADDR_W + 1;

    state_e            state_q, state_d;
    op_e               op_q, op_d;
    logic              desc_q, desc_d;
    logic              skip_q, skip_d;
    logic [LEN_W-1:0]  cnt_q, cnt_d;
    logic              busy_q, busy_d;
    logic              done_q, done_d;
    logic              skipped_q, skipped_d;
    logic [ADDR_W-1:0] rd_addr_a_q, rd_addr_a_d;
    logic [ADDR_W-1:0] rd_addr_b_q, rd_addr_b_d;
    logic [ADDR_W-1:0] wr_addr_q, wr_addr_d;
    logic              wr_en_q, wr_en_d;

    logic              gate_c;
    logic              desc_c;
    logic [ADDR_W-1:0] dist_c;
    logic [ADDR_W-1:0] off0_c;
    logic [ADDR_W-1:0] step_c;
    logic [WORD_W-1:0] alu_res;

    // Request decode: gate, wrap-aware overlap direction, first-element offset
    always_comb begin
        gate_c = !bus.cond_en || bus.cond_flag;
        dist_c = bus.origin - bus.modifier;
        desc_c = (dist_c != '0) && (LEN_W'(dist_c) < bus.length);
        off0_c = desc_c ? ADDR_W'(bus.length - LEN_W'(1)) : '0;
        step_c = desc_q ? '1 : ADDR_W'(1);
    end

    // Next-state and registered-output logic
    always_comb begin
        state_d     = state_q;
        op_d        = op_q;
        desc_d      = desc_q;
        skip_d      = skip_q;
        cnt_d       = cnt_q;
        busy_d      = busy_q;
        done_d      = 1'b0;
        skipped_d   = 1'b0;
        rd_addr_a_d = rd_addr_a_q;
        rd_addr_b_d = rd_addr_b_q;
        wr_addr_d   = wr_addr_q;
        wr_en_d     = 1'b0;

        case (state_q)
            S_IDLE: begin
                if (bus.start) begin
                    op_d   = bus.op;
                    desc_d = desc_c;
                    busy_d = 1'b1;
                    if (!gate_c || (bus.length == '0)) begin
                        skip_d  = !gate_c;
                        state_d = S_FIN;
                    end else begin
                        skip_d      = 1'b0;
                        cnt_d       = bus.length - LEN_W'(1);
                        rd_addr_a_d = bus.origin + off0_c;
                        rd_addr_b_d = bus.modifier + off0_c;
                        state_d     = S_RUN;
                    end
                end
            end
            S_RUN: begin
                // Write the element whose read was issued last cycle
                wr_en_d   = 1'b1;
                wr_addr_d = rd_addr_a_q;
                if (cnt_q == '0) begin
                    state_d = S_DRAIN;
                end else begin
                    cnt_d       = cnt_q - LEN_W'(1);
                    rd_addr_a_d = rd_addr_a_q + step_c;
                    rd_addr_b_d = rd_addr_b_q + step_c;
                end
            end
            S_DRAIN: begin
                state_d = S_FIN;
            end
            S_FIN: begin
                done_d    = 1'b1;
                skipped_d = skip_q;
                busy_d    = 1'b0;
                state_d   = S_IDLE;
            end
            default: state_d = S_IDLE;
        endcase
    end

    // State and output registers; reset aborts any operation in flight
    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            state_q     <= S_IDLE;
            op_q        <= OP_SUB;
            desc_q      <= 1'b0;
            skip_q      <= 1'b0;
            cnt_q       <= '0;
            busy_q      <= 1'b0;
            done_q      <= 1'b0;
            skipped_q   <= 1'b0;
            rd_addr_a_q <= '0;
            rd_addr_b_q <= '0;
            wr_addr_q   <= '0;
            wr_en_q     <= 1'b0;
        end else begin
            state_q     <= state_d;
            op_q        <= op_d;
            desc_q      <= desc_d;
            skip_q      <= skip_d;
            cnt_q       <= cnt_d;
            busy_q      <= busy_d;
            done_q      <= done_d;
            skipped_q   <= skipped_d;
            rd_addr_a_q <= rd_addr_a_d;
            rd_addr_b_q <= rd_addr_b_d;
            wr_addr_q   <= wr_addr_d;
            wr_en_q     <= wr_en_d;
        end
    end

    diff_map_alu #(.WORD_W(WORD_W)) u_alu (
        .op     (op_q),
        .a      (bus.rd_data_a),
        .b      (bus.rd_data_b),
        .result (alu_res)
    );

    // Read data arrives one cycle after the address, so write data passes straight
    // from the ALU; it is forced to zero whenever no write is due
    assign bus.wr_data   = wr_en_q ? alu_res : '0;
    assign bus.wr_en     = wr_en_q;
    assign bus.wr_addr   = wr_addr_q;
    assign bus.rd_addr_a = rd_addr_a_q;
    assign bus.rd_addr_b = rd_addr_b_q;
    assign bus.busy      = busy_q;
    assign bus.done      = done_q;
    assign bus.skipped   = skipped_q;

endmodule

// File: tb/tb_diff_map_engine.sv
// Scoreboard bench for diff_map_engine with a synchronous-read register file model.
module tb_diff_map_engine;
    import diff_map_pkg::*;

    localparam int unsigned WW = 32;
    localparam int unsigned AW = 6;

    typedef struct {
        logic [AW-1:0] addr;
        logic [WW-1:0] data;
    } wr_t;

    typedef struct {
        logic skip;
        int   cyc;
    } dn_t;

    logic clk = 1'b0;
    logic rst;
    always #5 clk = ~clk;

    diff_map_if #(.WORD_W(WW), .ADDR_W(AW)) dm ();

    diff_map_engine #(.WORD_W(WW), .ADDR_W(AW)) dut (
        .clk (clk),
        .rst (rst),
        .bus (dm)
    );

    logic [WW-1:0] mem [64];
    logic          ld_en   = 1'b0;
    logic [AW-1:0] ld_addr = '0;
    logic [WW-1:0] ld_data = '0;

    int cyc      = 0;
    int n_checks = 0;
    int n_fail   = 0;

    wr_t wq[$];
    dn_t dq[$];

    // Register file: preload port, engine write port, two synchronous read ports
    always @(posedge clk) begin
        if (ld_en) mem[ld_addr] <= ld_data;
        else if (dm.wr_en === 1'b1) mem[dm.wr_addr] <= dm.wr_data;
        dm.rd_data_a <= mem[dm.rd_addr_a];
        dm.rd_data_b <= mem[dm.rd_addr_b];
    end

    always @(posedge clk) cyc <= cyc + 1;

    task automatic check(input string name, input logic [63:0] got, input logic [63:0] want);
        n_checks++;
        if (got !== want) begin
            n_fail++;
            $display("FAIL %s: got %h want %h (cycle %0d)", name, got, want, cyc);
        end
    endtask

    // Monitor: pop expectations whenever the DUT writes or completes
    always @(negedge clk) begin : monitor
        wr_t w;
        dn_t d;
        if (rst === 1'b0) begin
            if (dm.wr_en === 1'b1) begin
                if (wq.size() == 0) begin
                    n_checks++;
                    n_fail++;
                    $display("FAIL unexpected_write: got addr %0d data %h want no write (cycle %0d)",
                             dm.wr_addr, dm.wr_data, cyc);
                end else begin
                    w = wq.pop_front();
                    check("wr_addr", 64'(dm.wr_addr), 64'(w.addr));
                    check("wr_data", 64'(dm.wr_data), 64'(w.data));
                end
            end
            if (dm.done === 1'b1) begin
                if (dq.size() == 0) begin
                    n_checks++;
                    n_fail++;
                    $display("FAIL unexpected_done: got done=1 want no done (cycle %0d)", cyc);
                end else begin
                    d = dq.pop_front();
                    check("done_cycle", 64'(cyc), 64'(d.cyc));
                    check("skipped", 64'(dm.skipped), 64'(d.skip));
                end
            end
        end
    end

    task automatic load(input logic [AW-1:0] a, input logic [WW-1:0] v);
        @(negedge clk);
        ld_en   = 1'b1;
        ld_addr = a;
        ld_data = v;
        @(negedge clk);
        ld_en   = 1'b0;
    endtask

    task automatic exp_wr(input logic [AW-1:0] a, input logic [WW-1:0] v);
        wr_t w;
        w.addr = a;
        w.data = v;
        wq.push_back(w);
    endtask

    task automatic memchk(input logic [AW-1:0] a, input logic [WW-1:0] v);
        check($sformatf("mem[%0d]", a), 64'(mem[a]), 64'(v));
    endtask

    // Issue one request and wait (bounded) for its completion
    task automatic run(input logic [AW-1:0] org, input logic [AW-1:0] mdf, input logic [AW:0] len,
                       input op_e o, input logic cen, input logic cfl,
                       input logic exp_skip, input logic poke);
        dn_t d;
        bit  seen;
        seen = 1'b0;
        @(negedge clk);
        dm.origin    = org;
        dm.modifier  = mdf;
        dm.length    = len;
        dm.op        = o;
        dm.cond_en   = cen;
        dm.cond_flag = cfl;
        dm.start     = 1'b1;
        d.skip = exp_skip;
        d.cyc  = (exp_skip || (len == '0)) ? cyc + 2 : cyc + int'(len) + 3;
        dq.push_back(d);
        @(negedge clk);
        dm.start = 1'b0;
        check("busy_after_start", 64'(dm.busy), 64'(1));
        if (poke) begin
            @(negedge clk);
            dm.start  = 1'b1;
            dm.origin = 6'd33;
            dm.op     = OP_ADD;
            @(negedge clk);
            dm.start  = 1'b0;
        end
        for (int k = 0; k < 200 && !seen; k++) begin
            if (dm.done === 1'b1) seen = 1'b1;
            else @(negedge clk);
        end
        if (!seen) begin
            n_checks++;
            n_fail++;
            $display("FAIL run_timeout: got no done want done within 200 cycles (cycle %0d)", cyc);
        end else begin
            check("busy_at_done", 64'(dm.busy), 64'(0));
        end
        @(negedge clk);
    endtask

    initial begin
        rst          = 1'b1;
        dm.start     = 1'b0;
        dm.origin    = '0;
        dm.modifier  = '0;
        dm.length    = '0;
        dm.op        = OP_SUB;
        dm.cond_en   = 1'b0;
        dm.cond_flag = 1'b0;

        // Reset state
        @(negedge clk);
        check("rst_busy", 64'(dm.busy), 64'(0));
        check("rst_done", 64'(dm.done), 64'(0));
        check("rst_skipped", 64'(dm.skipped), 64'(0));
        check("rst_wr_en", 64'(dm.wr_en), 64'(0));
        check("rst_rd_addr_a", 64'(dm.rd_addr_a), 64'(0));
        check("rst_rd_addr_b", 64'(dm.rd_addr_b), 64'(0));
        check("rst_wr_addr", 64'(dm.wr_addr), 64'(0));
        check("rst_wr_data", 64'(dm.wr_data), 64'(0));
        rst = 1'b0;

        // Basic subtract, with a start pulse while busy that must be ignored
        load(0, 10); load(1, 20); load(2, 30); load(3, 40);
        load(8, 1);  load(9, 2);  load(10, 3); load(11, 4);
        exp_wr(0, 9); exp_wr(1, 18); exp_wr(2, 27); exp_wr(3, 36);
        run(0, 8, 4, OP_SUB, 1'b0, 1'b0, 1'b0, 1'b1);
        memchk(0, 9); memchk(1, 18); memchk(2, 27); memchk(3, 36);

        // Gate false: skipped, no writes
        run(0, 8, 5, OP_SUB, 1'b1, 1'b0, 1'b1, 1'b0);
        memchk(0, 9);

        // Zero length with gate open: done without skip
        run(0, 8, 0, OP_SUB, 1'b0, 1'b0, 1'b0, 1'b0);

        // Overlapping ranges, B below A: descending order, snapshot result
        load(2, 1); load(3, 2); load(4, 3); load(5, 4); load(6, 5); load(7, 6);
        exp_wr(7, 2); exp_wr(6, 2); exp_wr(5, 2); exp_wr(4, 2);
        run(4, 2, 4, OP_SUB, 1'b0, 1'b0, 1'b0, 1'b0);
        memchk(4, 2); memchk(5, 2); memchk(6, 2); memchk(7, 2);

        // Address wrap at the top of the register file
        load(62, 100); load(63, 200); load(0, 5); load(1, 7); load(2, 9); load(3, 11);
        exp_wr(62, 95); exp_wr(63, 193); exp_wr(0, 32'hFFFF_FFFC); exp_wr(1, 32'hFFFF_FFFC);
        run(62, 0, 4, OP_SUB, 1'b0, 1'b0, 1'b0, 1'b0);
        memchk(62, 95); memchk(63, 193); memchk(0, 32'hFFFF_FFFC); memchk(1, 32'hFFFF_FFFC);

        // Add with gate enabled and flag set (executes), carry wraps
        load(20, 32'hFFFF_FFFF); load(21, 5); load(40, 2); load(41, 6);
        exp_wr(20, 1); exp_wr(21, 11);
        run(20, 40, 2, OP_ADD, 1'b1, 1'b1, 1'b0, 1'b0);

        // XOR, single element
        load(30, 32'hF0F0_F0F0); load(31, 32'hFF00_FF00);
        exp_wr(30, 32'h0FF0_0FF0);
        run(30, 31, 1, OP_XOR, 1'b0, 1'b0, 1'b0, 1'b0);

        // Signed saturating subtract at both extremes
        load(50, 32'h8000_0000); load(51, 1); load(52, 32'h8000_0000);
`ifdef DIFF_MAP_SAT_EN
        exp_wr(50, 32'h8000_0000); exp_wr(51, 32'h7FFF_FFFF);
`else
        exp_wr(50, 32'h7FFF_FFFF); exp_wr(51, 32'h8000_0001);
`endif
        run(50, 51, 2, OP_SSUB, 1'b0, 1'b0, 1'b0, 1'b0);

        // Reset after the second write of a length-8 run
        load(16, 1); load(17, 2); load(18, 3); load(24, 10); load(25, 20); load(26, 30);
        exp_wr(16, 11); exp_wr(17, 22);
        @(negedge clk);
        dm.origin    = 6'd16;
        dm.modifier  = 6'd24;
        dm.length    = 7'd8;
        dm.op        = OP_ADD;
        dm.cond_en   = 1'b0;
        dm.cond_flag = 1'b0;
        dm.start     = 1'b1;
        @(posedge clk);
        #1 dm.start = 1'b0;
        repeat (3) @(posedge clk);
        #1 rst = 1'b1;
        @(negedge clk);
        check("abort_busy", 64'(dm.busy), 64'(0));
        check("abort_wr_en", 64'(dm.wr_en), 64'(0));
        check("abort_rd_addr_a", 64'(dm.rd_addr_a), 64'(0));
        @(negedge clk);
        rst = 1'b0;
        repeat (12) @(negedge clk);
        check("abort_pending_writes", 64'(wq.size()), 64'(0));
        memchk(16, 11); memchk(17, 22); memchk(18, 3);

        // Normal operation after abort
        load(10, 50); load(11, 60); load(12, 70); load(13, 5); load(14, 6);
        exp_wr(10, 32'hFFFF_FFEC); exp_wr(11, 55); exp_wr(12, 64);
        run(10, 12, 3, OP_SUB, 1'b0, 1'b0, 1'b0, 1'b0);
        memchk(10, 32'hFFFF_FFEC); memchk(11, 55); memchk(12, 64);

        repeat (3) @(negedge clk);
        check("pending_writes", 64'(wq.size()), 64'(0));
        check("pending_dones", 64'(dq.size()), 64'(0));

        $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
        $finish;
    end

endmodule

// File: doc/diff_map_engine.md
DIFF_MAP_ENGINE -- requirements
Module: diff_map_engine

Interface
REQ-001 Parameter WORD_W, default 32, element width in bits.
REQ-002 Parameter ADDR_W, default 6, element address width; the register file holds 2**ADDR_W words.
REQ-003 Port clk  in  1  single clock; all state changes on rising edge.
REQ-004 Port rst  in  1  asynchronous, active-high reset.
REQ-005 Port start  in  1  request; sampled only in IDLE.
REQ-006 Port origin, modifier  in  ADDR_W each  base addresses of the destination/A range and the B range.
REQ-007 Port length  in  ADDR_W+1  element count, 0..2**ADDR_W.
REQ-008 Port op  in  2  00 A-B, 01 A+B, 10 A^B, 11 saturating signed A-B.
REQ-009 Port cond_en, cond_flag  in  1 each  conditional gate; operation executes when cond_en=0 or cond_flag=1.
REQ-010 Port busy  out  1  high from the cycle after accepted start until done.
REQ-011 Port done  out  1  one-cycle completion pulse; skipped  out  1  valid with done, 1 when the gate suppressed execution.
REQ-012 Ports rd_addr_a, rd_addr_b  out  ADDR_W; rd_data_a, rd_data_b  in  WORD_W  synchronous read, data one cycle after address.
REQ-013 Ports wr_en  out  1; wr_addr  out  ADDR_W; wr_data  out  WORD_W  single write port.

Function
REQ-014 The FSM shall have states IDLE, RUN, DRAIN, FIN.
REQ-015 IDLE: start=1 latches all inputs; gate false or length=0 -> FIN with skipped=(gate false), else -> RUN.
REQ-016 RUN issues one read pair per cycle for element i (rd_addr_a=origin+i, rd_addr_b=modifier+i); after the last element -> DRAIN.
REQ-017 Element i shall be written (wr_addr=origin+i) exactly one cycle after its read; DRAIN performs the final write then -> FIN.
REQ-018 FIN asserts done for one cycle then -> IDLE; for length N>0 done occurs N+2 cycles after the accepted start edge.
REQ-019 Addresses shall wrap modulo 2**ADDR_W; arithmetic is modulo 2**WORD_W except op 11.
REQ-020 Result shall equal snapshot semantics: every operand read sees the value before the operation started.
REQ-021 To guarantee REQ-020, when modifier<origin and ranges overlap (origin-modifier < length, wrap-aware) elements shall be processed descending (i=N-1..0); otherwise ascending.
REQ-022 start while busy shall be ignored; no queuing.
REQ-023 wr_en shall be 0 in IDLE, FIN and whenever no element write is due.

Reset
REQ-024 rst shall force IDLE, busy=0, done=0, skipped=0, wr_en=0, all address/data outputs 0.
REQ-025 rst mid-operation aborts immediately; no further writes and no done pulse.

Configuration
REQ-026 With DIFF_MAP_SAT_EN defined, op 11 shall clamp signed A-B to [-2**(WORD_W-1), 2**(WORD_W-1)-1].
REQ-027 Without DIFF_MAP_SAT_EN, op 11 shall behave as op 00 and no saturation logic shall be present.

Structure
REQ-028 Op encoding enum, FSM state enum and parameter defaults shall reside in the shared package diff_map_pkg.
REQ-029 The element datapath shall be a combinational sub-module diff_map_alu (op, A, B -> result); FSM, direction logic and addressing remain in diff_map_engine.

Verification
REQ-030 origin=0, modifier=8, length=4, op=00, mem[0..3]=10,20,30,40, mem[8..11]=1,2,3,4 -> mem[0..3]=9,18,27,36, done at cycle 6, skipped=0.
REQ-031 cond_en=1, cond_flag=0, length=5 -> no wr_en, done at cycle 1 with skipped=1; length=0, cond_en=0 -> done at cycle 1, skipped=0.
REQ-032 Overlap origin=4, modifier=2, length=4, mem[2..7]=1..6 -> descending order, mem[4..7]=2,2,2,2 (snapshot).
REQ-033 origin=62, modifier=0, length=4, ADDR_W=6 -> writes to 62,63,0,1; wr_addr never exceeds 63.
REQ-034 With DIFF_MAP_SAT_EN, op=11, A=0x80000000, B=1 -> 0x80000000; without macro -> 0x7FFFFFFF.
REQ-035 rst asserted after second write of a length-8 run -> only two words changed, done never pulses, busy=0; next start executes normally.
